// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus layouts for the memory-access stage.
// Field bit positions are fixed by the packed struct member order (MSB first).
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 110;
    localparam int MS_TO_WS_BUS_WD = 74;
    localparam int MS_FWD_BUS_WD   = 40;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100,
        LD_WL = 3'b101,
        LD_WR = 3'b110
    } load_op_e;

    // rt_value 109:78, load_op 77:75, res_from_mem 74, byte_we 73:70,
    // gr_we 69, dest 68:64, alu_result 63:32, pc 31:0
    typedef struct packed {
        logic [31:0] rt_value;
        logic [2:0]  load_op;
        logic        res_from_mem;
        logic [3:0]  byte_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [3:0]  byte_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        valid;
        logic        gr_we;
        logic        load_pending;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: byte/halfword select with sign/zero extension.
// lwl/lwr merging is compiled in only when MEM_UNALIGNED_LOAD_EN is defined.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    output logic [31:0] load_result
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = rdata >> {off, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = off[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: load_result gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        load_result = rdata;
        case (load_op)
            LD_B:  load_result = {{24{byte_v[7]}}, byte_v};
            LD_BU: load_result = {24'h0, byte_v};
            LD_H:  load_result = {{16{half_v[15]}}, half_v};
            LD_HU: load_result = {16'h0, half_v};
`ifdef MEM_UNALIGNED_LOAD_EN
            LD_WL: begin
                case (off)
                    2'd0:    load_result = {rdata[7:0],  rt_value[23:0]};
                    2'd1:    load_result = {rdata[15:0], rt_value[15:0]};
                    2'd2:    load_result = {rdata[23:0], rt_value[7:0]};
                    default: load_result = rdata;
                endcase
            end
            LD_WR: begin
                case (off)
                    2'd0:    load_result = rdata;
                    2'd1:    load_result = {rt_value[31:24], rdata[31:8]};
                    2'd2:    load_result = {rt_value[31:16], rdata[31:16]};
                    default: load_result = {rt_value[31:8],  rdata[31:24]};
                endcase
            end
`endif
            default: load_result = rdata;
        endcase
    end

`ifndef MEM_UNALIGNED_LOAD_EN
    logic unused_rt_value;
    assign unused_rt_value = ^rt_value;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX->MEM capture, load response wait/buffer, WB handshake, ID bypass.
// Optional lwl/lwr support is selected by MEM_UNALIGNED_LOAD_EN (see mem_load_align).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    es_to_ms_t   bus_q, bus_d;
    logic        ms_valid_q, ms_valid_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_ready_go;
    logic [31:0] load_data;
    logic [31:0] load_result;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;
    ms_fwd_t     fwd_bus;

    assign load_data    = buf_valid_q ? rdata_buf_q : data_sram_rdata;
    assign final_result = bus_q.res_from_mem ? load_result : bus_q.alu_result;

    mem_load_align u_load_align (
        .load_op     (bus_q.load_op),
        .off         (bus_q.alu_result[1:0]),
        .rdata       (load_data),
        .rt_value    (bus_q.rt_value),
        .load_result (load_result)
    );

    always_comb begin
        ms_ready_go    = !bus_q.res_from_mem || data_sram_data_ok || buf_valid_q;
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);

        ms_valid_d  = ms_allowin ? es_to_ms_valid : ms_valid_q;
        bus_d       = (es_to_ms_valid && ms_allowin) ? es_to_ms_t'(es_to_ms_bus) : bus_q;
        buf_valid_d = buf_valid_q;
        rdata_buf_d = rdata_buf_q;
        // A response that WB cannot take yet is parked until the load leaves.
        if (ms_to_ws_valid && ws_allowin) begin
            buf_valid_d = 1'b0;
        end else if (ms_valid_q && bus_q.res_from_mem && data_sram_data_ok && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_comb begin
        ws_bus.byte_we      = bus_q.byte_we;
        ws_bus.gr_we        = bus_q.gr_we;
        ws_bus.dest         = bus_q.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = bus_q.pc;

        fwd_bus = '0;
        if (ms_valid_q) begin
            fwd_bus.valid        = 1'b1;
            fwd_bus.gr_we        = bus_q.gr_we;
            fwd_bus.load_pending = bus_q.res_from_mem && !ms_ready_go;
            fwd_bus.dest         = bus_q.dest;
            fwd_bus.result       = final_result;
        end
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_fwd_bus   = fwd_bus;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            bus_q       <= bus_d;
        end
    end

    // NOTE: data-only register left without reset; it is only read while buf_valid_q is set.
    always_ff @(posedge clk) begin
        rdata_buf_q <= rdata_buf_d;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized traffic
// compared against an instruction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;

    ms_to_ws_t ws;
    ms_fwd_t   fw;
    assign ws = ms_to_ws_bus;
    assign fw = ms_fwd_bus;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk(input logic [2:0] op, input logic rfm,
                                                      input logic [31:0] alu, input logic [31:0] rt,
                                                      input logic [4:0] dest);
        es_to_ms_t p;
        p.rt_value     = rt;
        p.load_op      = op;
        p.res_from_mem = rfm;
        p.byte_we      = 4'h0;
        p.gr_we        = 1'b1;
        p.dest         = dest;
        p.alu_result   = alu;
        p.pc           = 32'hBFC0_0100;
        return p;
    endfunction

    // Reference load semantics written as plain shifts and masks on the memory word.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] m, input logic [31:0] rt);
        int unsigned sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [63:0] w;
        sh = 8 * int'(off);
        b  = 8'(m >> sh);
        h  = 16'(m >> (16 * int'(off[1])));
        w  = 64'(m);
        case (op)
            3'd1: return 32'($signed(b));
            3'd2: return 32'(b);
            3'd3: return 32'($signed(h));
            3'd4: return 32'(h);
`ifdef MEM_UNALIGNED_LOAD_EN
            3'd5: begin
                sh = 8 * (3 - int'(off));
                w  = (64'(m) << sh) | (64'(rt) & ((64'd1 << sh) - 64'd1));
                return w[31:0];
            end
            3'd6: begin
                w = (64'(m) >> sh) | (64'(rt) & ~(64'hFFFF_FFFF >> sh) & 64'hFFFF_FFFF);
                return w[31:0];
            end
`endif
            default: return w[31:0];
        endcase
    endfunction

    initial begin
        bit          m_have;
        bit          m_hasdata;
        es_to_ms_t   m_p;
        es_to_ms_t   np;
        logic [31:0] m_data;
        logic [31:0] m_word;
        logic [31:0] fin;
        logic [127:0] r;
        bit          ready;
        bit          exp_valid;
        bit          exp_allow;
        logic [39:0] exp_fwd;
        logic [73:0] exp_bus;

        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        tick();
        tick();
        reset = 1'b0;
        sample();
        check("rst_allowin", 128'(ms_allowin), 128'(1'b1));
        check("rst_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        check("rst_fwd", 128'(ms_fwd_bus), 128'(40'h0));
        tick();

        // Non-load passes through in one cycle.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_W, 1'b0, 32'h1234_5678, 32'h0, 5'd5);
        tick();
        es_to_ms_valid = 1'b0;
        sample();
        check("add_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        check("add_result", 128'(ws.final_result), 128'(32'h1234_5678));
        check("add_dest", 128'(ws.dest), 128'(5'd5));
        check("add_fwd", 128'(ms_fwd_bus), 128'({1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678}));
        tick();
        sample();
        check("add_drain", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();

        // lb off 3 and lhu off 2, data in the first cycle.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_B, 1'b1, 32'h0000_1003, 32'h0, 5'd7);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_7F01;
        sample();
        check("lb_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        check("lb_result", 128'(ws.final_result), 128'(32'hFFFF_FF80));
        tick();
        data_sram_data_ok = 1'b0;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(LD_HU, 1'b1, 32'h0000_1002, 32'h0, 5'd8);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        sample();
        check("lhu_result", 128'(ws.final_result), 128'(32'h0000_80FF));
        tick();
        data_sram_data_ok = 1'b0;

        // lw with response delayed 3 cycles.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_W, 1'b1, 32'h0000_2000, 32'h0, 5'd9);
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_sram_rdata = $urandom;
            sample();
            check("lw_wait_allowin", 128'(ms_allowin), 128'(1'b0));
            check("lw_wait_pending", 128'(fw.load_pending), 128'(1'b1));
            check("lw_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5A5A_A5A5;
        sample();
        check("lw_late_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        check("lw_late_result", 128'(ws.final_result), 128'(32'h5A5A_A5A5));
        check("lw_late_pending", 128'(fw.load_pending), 128'(1'b0));
        tick();
        data_sram_data_ok = 1'b0;
        sample();
        check("lw_late_once", 128'(ms_to_ws_valid), 128'(1'b0));
        tick();

        // Response arrives while WB stalls: buffered and held.
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_W, 1'b1, 32'h0000_3000, 32'h0, 5'd10);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_BABE;
        sample();
        check("buf_first", 128'(ws.final_result), 128'(32'hCAFE_BABE));
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        sample();
        check("buf_hold_result", 128'(ws.final_result), 128'(32'hCAFE_BABE));
        check("buf_hold_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        check("buf_hold_allowin", 128'(ms_allowin), 128'(1'b0));
        tick();
        ws_allowin = 1'b1;
        sample();
        check("buf_release_result", 128'(ws.final_result), 128'(32'hCAFE_BABE));
        check("buf_release_allowin", 128'(ms_allowin), 128'(1'b1));
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_W, 1'b1, 32'h0000_3004, 32'h0, 5'd11);
        tick();
        es_to_ms_valid = 1'b0;
        sample();
        check("buf_cleared_pending", 128'(fw.load_pending), 128'(1'b1));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1357_9BDF;
        sample();
        check("buf_cleared_result", 128'(ws.final_result), 128'(32'h1357_9BDF));
        tick();
        data_sram_data_ok = 1'b0;

        // lwl off 1 and lwr off 2 (decode as lw when the option is absent).
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_WL, 1'b1, 32'h0000_4001, 32'h1122_3344, 5'd12);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAABB_CCDD;
        sample();
`ifdef MEM_UNALIGNED_LOAD_EN
        check("lwl_result", 128'(ws.final_result), 128'(32'hCCDD_3344));
`else
        check("lwl_as_lw", 128'(ws.final_result), 128'(32'hAABB_CCDD));
`endif
        tick();
        data_sram_data_ok = 1'b0;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(LD_WR, 1'b1, 32'h0000_4002, 32'h1122_3344, 5'd13);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        sample();
`ifdef MEM_UNALIGNED_LOAD_EN
        check("lwr_result", 128'(ws.final_result), 128'(32'h1122_AABB));
`else
        check("lwr_as_lw", 128'(ws.final_result), 128'(32'hAABB_CCDD));
`endif
        tick();
        data_sram_data_ok = 1'b0;

        // Reset during WAIT; the late response is dropped.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LD_W, 1'b1, 32'h0000_5000, 32'h0, 5'd14);
        tick();
        es_to_ms_valid = 1'b0;
        sample();
        check("rstwait_pending", 128'(fw.load_pending), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset             = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_8888;
        sample();
        check("rstwait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        check("rstwait_allowin", 128'(ms_allowin), 128'(1'b1));
        check("rstwait_fwd", 128'(ms_fwd_bus), 128'(40'h0));
        tick();
        data_sram_data_ok = 1'b0;

        // Randomized traffic against an instruction-level model.
        m_have    = 1'b0;
        m_hasdata = 1'b0;
        m_p       = '0;
        m_data    = '0;
        for (int c = 0; c < 400; c++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            np = r[ES_TO_MS_BUS_WD-1:0];
            es_to_ms_valid  = ($urandom_range(0, 3) != 0);
            es_to_ms_bus    = np;
            ws_allowin      = ($urandom_range(0, 3) != 0);
            data_sram_rdata = $urandom;
            if (m_have && m_p.res_from_mem)
                data_sram_data_ok = !m_hasdata && ($urandom_range(0, 2) == 0);
            else
                data_sram_data_ok = ($urandom_range(0, 7) == 0);

            ready     = m_have && (!m_p.res_from_mem || m_hasdata || data_sram_data_ok);
            m_word    = m_hasdata ? m_data : data_sram_rdata;
            fin       = m_p.res_from_mem ? ref_load(m_p.load_op, m_p.alu_result[1:0], m_word, m_p.rt_value)
                                         : m_p.alu_result;
            exp_valid = ready;
            exp_allow = !m_have || (ready && ws_allowin);
            exp_fwd   = m_have ? {1'b1, m_p.gr_we, m_p.res_from_mem && !ready, m_p.dest, fin} : 40'h0;
            exp_bus   = {m_p.byte_we, m_p.gr_we, m_p.dest, fin, m_p.pc};

            sample();
            check("rnd_valid", 128'(ms_to_ws_valid), 128'(exp_valid));
            check("rnd_allowin", 128'(ms_allowin), 128'(exp_allow));
            check("rnd_fwd", 128'(ms_fwd_bus), 128'(exp_fwd));
            if (exp_valid)
                check("rnd_bus", 128'(ms_to_ws_bus), 128'(exp_bus));

            if (ready && ws_allowin) begin
                m_have    = 1'b0;
                m_hasdata = 1'b0;
            end else if (m_have && m_p.res_from_mem && data_sram_data_ok && !m_hasdata) begin
                m_hasdata = 1'b1;
                m_data    = data_sram_rdata;
            end
            if (exp_allow && es_to_ms_valid) begin
                m_have    = 1'b1;
                m_hasdata = 1'b0;
                m_p       = np;
            end
            tick();
        end
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and the write-back stage. Accepts one instruction per cycle from EX and, for loads, waits for the data-SRAM response. It extracts and sign- or zero-extends the loaded byte, halfword or word, then forwards the result to WB over the standard valid/allowin handshake. It also drives a bypass/stall bus back to ID.

## Interface
- ES_TO_MS_BUS_WD, 110, EX→MEM bus width: rt_value 109:78, load_op 77:75, res_from_mem 74, byte_we 73:70, gr_we 69, dest 68:64, alu_result 63:32 (low 2 bits = byte offset), pc 31:0
- MS_TO_WS_BUS_WD, 74, MEM→WB bus width: byte_we 73:70, gr_we 69, dest 68:64, final_result 63:32, pc 31:0
- MS_FWD_BUS_WD, 40, MEM→ID bypass bus: valid 39, gr_we 38, load_pending 37, dest 36:32, result 31:0
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ms_allowin  out  1  MEM can accept an instruction this cycle
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  ES_TO_MS_BUS_WD  EX payload
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MEM output valid
- ms_to_ws_bus  out  MS_TO_WS_BUS_WD  MEM payload
- data_sram_data_ok  in  1  one-cycle read-response pulse for the load issued in EX
- data_sram_rdata  in  32  read data, valid with data_ok
- ms_fwd_bus  out  MS_FWD_BUS_WD  bypass/stall info to ID

## Operation
- Payload register es_to_ms_bus_r is captured when es_to_ms_valid && ms_allowin. ms_valid is updated to es_to_ms_valid whenever ms_allowin is high.
- States (derived from ms_valid, res_from_mem and buf_valid):
  - EMPTY: ms_valid = 0.
  - WAIT: valid load with no data yet.
  - READY: non-load, data_ok this cycle, or buf_valid set.
- ms_ready_go = !res_from_mem || data_sram_data_ok || buf_valid.
- ms_to_ws_valid = ms_valid && ms_ready_go.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- Response buffer: if data_ok arrives while ms_valid && res_from_mem && !ws_allowin, capture rdata_buf ← data_sram_rdata and set buf_valid. buf_valid clears when the instruction leaves (ms_to_ws_valid && ws_allowin).
- Load data source: buf_valid ? rdata_buf : data_sram_rdata.
- data_ok while ms_valid = 0, or for a non-load, is ignored.
- Load extraction uses off = alu_result[1:0], little-endian. load_op encodings:
  - 000 lw: full word.
  - 001 lb: sign-extended byte at off.
  - 010 lbu: zero-extended byte at off.
  - 011 lh: sign-extended halfword at off[1].
  - 100 lhu: zero-extended halfword at off[1].
  - 101 lwl: off 0/1/2/3 → {m[7:0],rt[23:0]} / {m[15:0],rt[15:0]} / {m[23:0],rt[7:0]} / m.
  - 110 lwr: off 0/1/2/3 → m / {rt[31:24],m[31:8]} / {rt[31:16],m[31:16]} / {rt[31:8],m[31:24]}.
  - 111: treated as lw.
- final_result = res_from_mem ? load data : alu_result.
- ms_to_ws_bus fields gr_we, dest, byte_we and pc pass through unchanged from the payload register.
- ms_fwd_bus fields:
  - valid = ms_valid.
  - gr_we = ms_valid && gr_we.
  - load_pending = ms_valid && res_from_mem && !ms_ready_go.
  - result = final_result.
  - ms_fwd_bus is all zero when !ms_valid.

## Timing
- Reset values: ms_valid = 0, buf_valid = 0, payload register = 0. Hence ms_allowin = 1, ms_to_ws_valid = 0, ms_fwd_bus = 0.
- Non-load: 1 cycle in MEM. ms_to_ws_valid is high in the first cycle after capture.
- Load: ms_to_ws_valid asserts combinationally in the cycle data_ok is seen. The earliest is the first cycle after capture, giving zero added latency.
- WB stall: the output holds stable (payload, buffered data, final_result) until ws_allowin.
- Simultaneous events:
  - data_ok together with ws_allowin: data is used directly, nothing is buffered.
  - An instruction leaving and a new one entering in the same cycle: buf_valid clears and the new payload loads.
- Reset mid-operation: clears ms_valid and buf_valid immediately. A late data_ok after reset is dropped.
- No combinational path from data_ok to ms_allowin other than through ms_ready_go. This path is accepted.

## Configuration
- MEM_UNALIGNED_LOAD_EN defined: lwl/lwr merge logic is compiled in, and rt_value is used.
- MEM_UNALIGNED_LOAD_EN undefined: load_op 101/110 decode as lw, rt_value is unused, and the merge muxes are absent.

## Structure
- mycpu.h holds:
  - the ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD and MS_FWD_BUS_WD width defines;
  - the LD_W/LD_B/LD_BU/LD_H/LD_HU/LD_WL/LD_WR encodings;
  - the field bit-position defines.
- One combinational sub-module, mem_load_align, with inputs load_op, off, rdata and rt_value and output load_result. It contains the MEM_UNALIGNED_LOAD_EN guard.
- The handshake, response buffer and bypass logic stay in mem_stage.

## Test plan
- Non-load add, alu_result = 0x12345678, gr_we = 1, dest = 5 → next cycle ms_to_ws_valid = 1, final_result = 0x12345678, dest = 5.
- lb at off = 3, rdata = 0x80FF7F01 → final_result = 0xFFFFFF80. lhu at off = 2 with the same data → 0x000080FF.
- lw with data_ok delayed 3 cycles:
  - ms_allowin = 0 and load_pending = 1 for 3 cycles;
  - then final_result = rdata and ms_to_ws_valid = 1 for one cycle.
- lw with data_ok = 0xCAFEBABE while ws_allowin = 0 for 2 cycles → buf_valid set; output 0xCAFEBABE stays stable until ws_allowin rises; buffer then clears.
- With MEM_UNALIGNED_LOAD_EN defined: lwl off = 1, rt = 0x11223344, rdata = 0xAABBCCDD → 0xCCDD3344. lwr off = 2 → 0x1122AABB.
- Reset asserted during WAIT, then data_ok pulses → ms_to_ws_valid stays 0 and ms_allowin = 1.
